bht_update_controller: RTL and testbench

- Sequences all writes into the 16-entry, 2-bit saturating-counter branch history table (BHT).
- Performs the table initialisation sweep after reset or flush, replacing the simulation-only `initial` block with a reset-driven mechanism.
- Queues resolved-branch outcomes from the MEM stage and drains them as serial read-modify-write updates through the table's single write port.
- Sits beside the predictor; the predictor's lookup read path is unchanged except that it is qualified by predict_enable.

---
 rtl/bht_update_controller_pkg.sv | 26 ++
 rtl/bht_update_controller_if.sv | 33 +++
 rtl/bht_update_fifo.sv | 52 +++++
 rtl/bht_update_controller.sv | 93 +++++++++
 tb/tb_bht_update_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bht_update_controller_pkg.sv
// Shared types and helpers for the BHT update path: default geometry, the
// controller state, the queued update entry and 2-bit saturating arithmetic.
package bht_pkg;

  localparam int         BHT_INDEX_BITS = 4;
  localparam logic [1:0] BHT_INIT_STATE = 2'b10;

  typedef enum logic {
    INIT,
    IDLE
  } bht_state_t;

  typedef struct packed {
    logic [BHT_INDEX_BITS-1:0] addr;
    logic                      taken;
  } bht_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == 2'b11) ? ctr : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_update_controller_if.sv
// Bundle of the resolved-branch update inputs, the BHT read/write port and
// the controller status outputs; master is the controller side.
interface bht_update_controller_if #(
  parameter int INDEX_BITS  = 4,
  parameter int QUEUE_DEPTH = 4
);

  logic                         upd_valid;
  logic [31:0]                  upd_addr;
  logic                         upd_taken;
  logic [INDEX_BITS-1:0]        tbl_rd_addr;
  logic [1:0]                   tbl_rd_data;
  logic                         tbl_wr_en;
  logic [INDEX_BITS-1:0]        tbl_wr_addr;
  logic [1:0]                   tbl_wr_data;
  logic                         predict_enable;
  logic                         busy;
  logic                         overflow;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;

  modport master (
    input  upd_valid, upd_addr, upd_taken, tbl_rd_data,
    output tbl_rd_addr, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output predict_enable, busy, overflow, queue_count
  );

  modport slave (
    output upd_valid, upd_addr, upd_taken, tbl_rd_data,
    input  tbl_rd_addr, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  predict_enable, busy, overflow, queue_count
  );

endinterface

// File: rtl/bht_update_fifo.sv
// Small synchronous FIFO of pending BHT updates with same-cycle push/pop and
// a synchronous clear; pointers carry an extra wrap bit for full/empty.
module bht_update_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  bht_entry_t             push_data,
  output bht_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  bht_entry_t     mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/bht_update_controller.sv
// Owns the single BHT write port: sweeps the table to INIT_STATE after reset
// or flush, then drains queued branch outcomes as read-modify-write updates.
module bht_update_controller
  import bht_pkg::*;
#(
  parameter int         INDEX_BITS  = BHT_INDEX_BITS,
  parameter int         QUEUE_DEPTH = 4,
  parameter logic [1:0] INIT_STATE  = BHT_INIT_STATE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  bht_update_controller_if.master bus
);

  localparam int                    CNT_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  bht_state_t            state;
  logic [INDEX_BITS-1:0] init_idx;
  logic                  predict_enable_q;
  logic                  overflow_q;
  bht_entry_t            push_entry;
  bht_entry_t            head;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.upd_addr[31:INDEX_BITS];

  // Outcomes arriving with a flush are discarded rather than queued.
  assign push_entry = '{addr: bus.upd_addr[INDEX_BITS-1:0], taken: bus.upd_taken};
  assign push       = bus.upd_valid & ~flush;
  assign pop        = (state == IDLE) & ~empty;

  bht_update_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .pop      (pop),
    .push_data(push_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state            <= INIT;
      init_idx         <= '0;
      predict_enable_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      if (state == INIT) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == LAST_IDX) begin
          state            <= IDLE;
          predict_enable_q <= 1'b1;
        end
      end else begin
        predict_enable_q <= 1'b1;
      end
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // The head's counter is read and rewritten in one cycle; a following update
  // to the same index reads the table after this write has landed.
  always_comb begin
    bus.tbl_rd_addr = head.addr;
    bus.tbl_wr_en   = pop;
    bus.tbl_wr_addr = head.addr;
    bus.tbl_wr_data = head.taken ? sat_inc(bus.tbl_rd_data) : sat_dec(bus.tbl_rd_data);
    if (state == INIT) begin
      bus.tbl_wr_en   = 1'b1;
      bus.tbl_wr_addr = init_idx;
      bus.tbl_wr_data = INIT_STATE;
    end
  end

  assign bus.predict_enable = predict_enable_q;
  assign bus.overflow       = overflow_q;
  assign bus.queue_count    = count;
  assign bus.busy           = (state == INIT) | (count != '0);

endmodule

// File: tb/tb_bht_update_controller.sv
// Scoreboard bench: stimulus feeds an outcome-level model that queues the
// expected table writes; a negedge monitor pops and compares every write.
module tb_bht_update_controller;

  localparam int QD    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;

  bht_update_controller_if #(.INDEX_BITS(4), .QUEUE_DEPTH(QD)) bus ();

  bht_update_controller #(
    .INDEX_BITS (4),
    .QUEUE_DEPTH(QD),
    .INIT_STATE (2'b10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  logic [1:0] tbl_mem [DEPTH];

  assign bus.tbl_rd_data = tbl_mem[bus.tbl_rd_addr];

  always @(posedge clk) begin
    if (bus.tbl_wr_en) tbl_mem[bus.tbl_wr_addr] <= bus.tbl_wr_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests_run;
  int   tests_failed;
  bit   checking;
  int   init_left;
  int   pend;
  bit   ovf_m;
  int   ref_tbl [DEPTH];
  exp_t exp_q [$];

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Cycle-level view: sweep writes come first, then one queued outcome per cycle.
  task automatic modelStep(input bit v, input logic [31:0] a, input bit tk,
                           input bit fl, input bit rs);
    bit   popped;
    exp_t e;
    if (rs || fl) begin
      init_left = DEPTH;
      pend      = 0;
      ovf_m     = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
        ref_tbl[i] = 2;
        e.addr = i;
        e.data = 2;
        exp_q.push_back(e);
      end
    end else begin
      popped = (init_left == 0) && (pend > 0);
      if (init_left > 0) init_left--;
      if (v) begin
        if (pend < QD || popped) begin
          e.addr = int'(a[3:0]);
          if (tk) e.data = (ref_tbl[e.addr] == 3) ? 3 : ref_tbl[e.addr] + 1;
          else    e.data = (ref_tbl[e.addr] == 0) ? 0 : ref_tbl[e.addr] - 1;
          ref_tbl[e.addr] = e.data;
          exp_q.push_back(e);
          pend++;
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (popped) pend--;
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input bit tk,
                               input bit fl, input bit rs);
    bus.upd_valid = v;
    bus.upd_addr  = a;
    bus.upd_taken = tk;
    flush         = fl;
    reset         = rs;
    @(posedge clk);
    modelStep(v, a, tk, fl, rs);
    checking = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput();
    exp_t e;
    check("tbl_wr_en", int'(bus.tbl_wr_en), int'((init_left > 0) || (pend > 0)));
    if (bus.tbl_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tbl_wr_addr", int'(bus.tbl_wr_addr), e.addr);
        check("tbl_wr_data", int'(bus.tbl_wr_data), e.data);
      end
    end
    check("predict_enable", int'(bus.predict_enable), int'(init_left == 0));
    check("busy", int'(bus.busy), int'((init_left > 0) || (pend > 0)));
    check("queue_count", int'(bus.queue_count), pend);
    check("overflow", int'(bus.overflow), int'(ovf_m));
  endtask

  always @(negedge clk) begin
    if (checking) checkOutput();
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    checking      = 1'b0;
    init_left     = 0;
    pend          = 0;
    ovf_m         = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_addr  = 32'h0;
    bus.upd_taken = 1'b0;
    flush         = 1'b0;
    reset         = 1'b1;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(18);

    // Saturating increment on index 5, then not-taken run on index 3.
    applyStimulus(1'b1, 32'h0000_1005, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hABCD_0003, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Five outcomes during the sweep: the fifth is dropped.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
    idle(20);

    // Flush at sweep index 9 with two entries queued; its outcome is ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
    idle(7);
    applyStimulus(1'b1, 32'h9, 1'b1, 1'b1, 1'b0);
    idle(20);

    // Full queue on the first IDLE cycle takes a push alongside the pop.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i + 10), 1'b1, 1'b0, 1'b0);
    idle(12);
    applyStimulus(1'b1, 32'he, 1'b0, 1'b0, 1'b0);
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, $urandom, 1'($urandom),
                    $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end
    idle(30);

    check("drained", exp_q.size(), 0);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
